nor4_response_checker: RTL and testbench

NOR4_RESPONSE_CHECKER -- requirements
Module: nor4_response_checker

---
 rtl/gate_check_pkg.sv | 21 ++
 rtl/nor4_ref_model.sv | 18 +
 rtl/nor4_response_checker.sv | 158 +++++++++++++++
 tb/tb_nor4_response_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
// Shared definitions for the family of small gate response checkers.
//   VEC_W   : width of the stimulus vector index ({a,b,c,d})
//   CNT_W   : width of the vector and error counters
//   ERR_SAT : value at which the error counter stops counting
//   state_t : checker run state (IDLE -> RUN -> DONE)
// -----------------------------------------------------------------------------
package gate_check_pkg;

  localparam int VEC_W = 4;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ERR_SAT = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nor4_ref_model.sv
// -----------------------------------------------------------------------------
// nor4_ref_model
// Combinational golden model of a 4-input NOR gate. Kept separate so other
// checkers can reuse it.
//   a, b, c, d : gate inputs
//   expected   : ~(a | b | c | d)
// -----------------------------------------------------------------------------
module nor4_ref_model (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic expected
);

  assign expected = ~(a | b | c | d);

endmodule

// File: rtl/nor4_response_checker.sv
// -----------------------------------------------------------------------------
// nor4_response_checker
// Samples a stream of {a,b,c,d} stimulus vectors together with the response e
// of a 4-input NOR gate under test, counts mismatches against the reference
// model, tracks which of the 16 input combinations have been exercised and
// reports a registered pass/fail verdict once NUM_VECTORS samples were taken.
//
// Parameters
//   NUM_VECTORS : samples per run (1..31)
//   ALL_COVER   : 1 = pass also requires every input combination seen
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a run (accepted in IDLE and DONE)
//   vec_valid       : sample a/b/c/d/e this cycle
//   a, b, c, d      : stimulus, vector index {a,b,c,d}
//   e               : gate response
//   busy, done      : state is RUN / DONE
//   pass            : verdict, meaningful while done=1
//   vec_count       : samples taken this run
//   err_count       : mismatches this run, saturating at 31
//   coverage        : bit i set once vector i was sampled
//   first_err_valid : a mismatch has been captured this run
//   first_err_vec   : vector index of the first mismatch
// -----------------------------------------------------------------------------
module nor4_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter bit          ALL_COVER   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      coverage,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_VECTORS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [15:0]      coverage_q, coverage_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [VEC_W-1:0] first_err_vec_q, first_err_vec_d;
  logic             pass_q, pass_d;

  logic             expected;
  logic             mismatch;
  logic [VEC_W-1:0] vec_idx;

  nor4_ref_model u_ref (
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .expected (expected)
  );

  assign vec_idx  = {a, b, c, d};
  assign mismatch = vec_valid & (e != expected);

  // Next-state logic. Starting a run (from IDLE or DONE) clears every
  // per-run record in the same edge. The final sample is folded into the
  // counters and the pass verdict on the edge that moves RUN -> DONE, so
  // pass is computed from the post-update values, not the stale ones.
  always_comb begin
    state_d           = state_q;
    vec_count_d       = vec_count_q;
    err_count_d       = err_count_q;
    coverage_d        = coverage_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;
    pass_d            = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d           = ST_RUN;
          vec_count_d       = '0;
          err_count_d       = '0;
          coverage_d        = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          pass_d            = 1'b0;
        end
      end

      ST_RUN: begin
        if (vec_valid) begin
          vec_count_d = vec_count_q + 1'b1;
          coverage_d  = coverage_q | (16'd1 << vec_idx);
          if (mismatch) begin
            if (err_count_q != ERR_SAT) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_vec_d   = vec_idx;
            end
          end
          if (vec_count_d == LAST_COUNT) begin
            state_d = ST_DONE;
            pass_d  = (err_count_d == '0) &&
                      (!ALL_COVER || (coverage_d == 16'hFFFF));
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      vec_count_q       <= '0;
      err_count_q       <= '0;
      coverage_q        <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_count_q       <= vec_count_d;
      err_count_q       <= err_count_d;
      coverage_q        <= coverage_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
      pass_q            <= pass_d;
    end
  end

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign coverage        = coverage_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_nor4_response_checker.sv
// -----------------------------------------------------------------------------
// tb_nor4_response_checker
// Drives three checker instances from one shared stimulus stream:
//   inst 0 : NUM_VECTORS=16, ALL_COVER=1
//   inst 1 : NUM_VECTORS=16, ALL_COVER=0
//   inst 2 : NUM_VECTORS=31, ALL_COVER=1
// A sample-list model derives every output from the recorded run.
// -----------------------------------------------------------------------------
module tb_nor4_response_checker;

  localparam int NV [3] = '{16, 16, 31};
  localparam bit AC [3] = '{1'b1, 1'b0, 1'b1};

  logic clk;
  logic rst;
  logic start, vec_valid, a, b, c, d, e;

  logic        busy_w [3];
  logic        done_w [3];
  logic        pass_w [3];
  logic [4:0]  vc_w   [3];
  logic [4:0]  ec_w   [3];
  logic [15:0] cov_w  [3];
  logic        fev_valid_w [3];
  logic [3:0]  fev_w  [3];

  int n_checks;
  int n_fail;

  // Model state: run phase (0 idle, 1 run, 2 done) and the samples of this run.
  int         ph [3];
  int         n  [3];
  logic [3:0] sv [3][32];
  logic       se [3][32];

  nor4_response_checker #(.NUM_VECTORS(16), .ALL_COVER(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .vec_count(vc_w[0]), .err_count(ec_w[0]), .coverage(cov_w[0]),
    .first_err_valid(fev_valid_w[0]), .first_err_vec(fev_w[0])
  );

  nor4_response_checker #(.NUM_VECTORS(16), .ALL_COVER(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .vec_count(vc_w[1]), .err_count(ec_w[1]), .coverage(cov_w[1]),
    .first_err_valid(fev_valid_w[1]), .first_err_vec(fev_w[1])
  );

  nor4_response_checker #(.NUM_VECTORS(31), .ALL_COVER(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .vec_count(vc_w[2]), .err_count(ec_w[2]), .coverage(cov_w[2]),
    .first_err_valid(fev_valid_w[2]), .first_err_vec(fev_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A NOR gate outputs 1 only for the all-zero input vector.
  function automatic logic gold(input logic [3:0] v);
    return (v == 4'h0);
  endfunction

  // Expected outputs {busy,done,pass,vec_count,err_count,coverage,fev_valid,fev}
  // derived purely from the list of samples recorded in the current run.
  function automatic logic [33:0] exp_out(input int i);
    int         mis;
    logic [15:0] cov;
    logic       fv;
    logic [3:0] fvec;
    logic [4:0] errs;
    logic       pass_e;
    mis  = 0;
    cov  = '0;
    fv   = 1'b0;
    fvec = '0;
    for (int k = 0; k < n[i]; k++) begin
      cov[sv[i][k]] = 1'b1;
      if (se[i][k] != gold(sv[i][k])) begin
        if (!fv) begin
          fv   = 1'b1;
          fvec = sv[i][k];
        end
        mis++;
      end
    end
    errs   = (mis > 31) ? 5'd31 : 5'(mis);
    pass_e = (ph[i] == 2) && (mis == 0) && (!AC[i] || cov == 16'hFFFF);
    return {ph[i] == 1, ph[i] == 2, pass_e, 5'(n[i]), errs, cov, fv, fvec};
  endfunction

  function automatic logic [33:0] dut_out(input int i);
    return {busy_w[i], done_w[i], pass_w[i], vc_w[i], ec_w[i], cov_w[i],
            fev_valid_w[i], fev_w[i]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One stimulus cycle: inputs change 2 time units after the rising edge.
  task automatic applyStimulus(input logic st, input logic vv,
                               input logic [3:0] vec, input logic ev);
    @(posedge clk);
    #2;
    start     = st;
    vec_valid = vv;
    {a, b, c, d} = vec;
    e         = ev;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Behavioural model of the run bookkeeping.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        ph[i] = 0;
        n[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ph[i] == 1) begin
          if (vec_valid) begin
            sv[i][n[i]] = {a, b, c, d};
            se[i][n[i]] = e;
            n[i]++;
            if (n[i] == NV[i]) ph[i] = 2;
          end
        end else if (start) begin
          ph[i] = 1;
          n[i]  = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("cycle_dut%0d", i), {30'b0, dut_out(i)}, {30'b0, exp_out(i)});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0;
      n[i]  = 0;
    end
    rst = 1'b1;
    start = 1'b0; vec_valid = 1'b0; {a, b, c, d} = 4'h0; e = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset_state", {30'b0, dut_out(0)}, 64'h0);

    // Correct full sweep
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) applyStimulus(1'b0, 1'b1, 4'(v), gold(4'(v)));
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("sweep_done", 64'(done_w[0]), 64'd1);
    checkOutput("sweep_pass", 64'(pass_w[0]), 64'd1);
    checkOutput("sweep_err", 64'(ec_w[0]), 64'd0);
    checkOutput("sweep_cov", 64'(cov_w[0]), 64'hFFFF);
    checkOutput("sweep_vc", 64'(vc_w[0]), 64'd16);

    // Sweep with a wrong response at vector 0
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) applyStimulus(1'b0, 1'b1, 4'(v), (v == 0) ? 1'b0 : gold(4'(v)));
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("err0_count", 64'(ec_w[0]), 64'd1);
    checkOutput("err0_vec", 64'(fev_w[0]), 64'h0);
    checkOutput("err0_valid", 64'(fev_valid_w[0]), 64'd1);
    checkOutput("err0_pass", 64'(pass_w[0]), 64'd0);

    // Repeated vector 5, correct responses
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 4'h5, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("rep5_pass_cover", 64'(pass_w[0]), 64'd0);
    checkOutput("rep5_pass_nocover", 64'(pass_w[1]), 64'd1);
    checkOutput("rep5_cov", 64'(cov_w[0]), 64'h0020);
    checkOutput("rep5_vc", 64'(vc_w[1]), 64'd16);

    // 31 inverted responses starting at index 3
    pulse_reset();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 31; k++) applyStimulus(1'b0, 1'b1, 4'((k + 3) % 16), ~gold(4'((k + 3) % 16)));
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("inv31_err", 64'(ec_w[2]), 64'd31);
    checkOutput("inv31_done", 64'(done_w[2]), 64'd1);
    checkOutput("inv31_fev", 64'(fev_w[2]), 64'h3);
    checkOutput("inv31_fev_valid", 64'(fev_valid_w[2]), 64'd1);
    checkOutput("inv16_err", 64'(ec_w[0]), 64'd16);

    // Asynchronous reset mid-run
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 7; v++) applyStimulus(1'b0, 1'b1, 4'(v), gold(4'(v)));
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_vc", 64'(vc_w[0]), 64'd7);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_dut0", {30'b0, dut_out(0)}, 64'h0);
    checkOutput("async_rst_dut2", {30'b0, dut_out(2)}, 64'h0);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("restart_busy", 64'(busy_w[0]), 64'd1);
    checkOutput("restart_vc", 64'(vc_w[0]), 64'd0);
    for (int v = 0; v < 16; v++) applyStimulus(1'b0, 1'b1, 4'(v), gold(4'(v)));
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("restart_done_pass", 64'(pass_w[0]), 64'd1);

    // start held high during RUN, gapped valid samples
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b1, 1'b1, 4'(v), gold(4'(v)));
      if (v < 15) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("gap_done", 64'(done_w[0]), 64'd1);
    checkOutput("gap_vc", 64'(vc_w[0]), 64'd16);
    checkOutput("gap_pass", 64'(pass_w[0]), 64'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
